// File: rtl/usb_rx_packet_if.sv
// Bundle of the ULPI receive stream and the packet-level results of usb_rx_packet.
// DEV_ADDR exists only when USB_RX_ADDR_FILTER_EN is defined.
interface usb_rx_packet_if;
    logic [7:0]  RX_DATA;
    logic        RX_STRB;
    logic        RX_END;
    logic        RX_FAIL;
`ifdef USB_RX_ADDR_FILTER_EN
    logic [6:0]  DEV_ADDR;
`endif
    logic [3:0]  PID;
    logic [6:0]  TOK_ADDR;
    logic [3:0]  TOK_ENDP;
    logic [10:0] FRAME_NUM;
    logic [7:0]  PAY_DATA;
    logic        PAY_STRB;
    logic [10:0] PAY_LEN;
    logic        PKT_DONE;
    logic        PKT_ERR;
    logic [2:0]  PKT_ERR_CODE;
    logic        BUSY;

`ifdef USB_RX_ADDR_FILTER_EN
    modport slave (
        input  RX_DATA, RX_STRB, RX_END, RX_FAIL, DEV_ADDR,
        output PID, TOK_ADDR, TOK_ENDP, FRAME_NUM, PAY_DATA, PAY_STRB,
               PAY_LEN, PKT_DONE, PKT_ERR, PKT_ERR_CODE, BUSY
    );
    modport master (
        output RX_DATA, RX_STRB, RX_END, RX_FAIL, DEV_ADDR,
        input  PID, TOK_ADDR, TOK_ENDP, FRAME_NUM, PAY_DATA, PAY_STRB,
               PAY_LEN, PKT_DONE, PKT_ERR, PKT_ERR_CODE, BUSY
    );
`else
    modport slave (
        input  RX_DATA, RX_STRB, RX_END, RX_FAIL,
        output PID, TOK_ADDR, TOK_ENDP, FRAME_NUM, PAY_DATA, PAY_STRB,
               PAY_LEN, PKT_DONE, PKT_ERR, PKT_ERR_CODE, BUSY
    );
    modport master (
        output RX_DATA, RX_STRB, RX_END, RX_FAIL,
        input  PID, TOK_ADDR, TOK_ENDP, FRAME_NUM, PAY_DATA, PAY_STRB,
               PAY_LEN, PKT_DONE, PKT_ERR, PKT_ERR_CODE, BUSY
    );
`endif
endinterface

// File: rtl/usb_rx_packet.sv
// USB packet receiver behind the ULPI PHY: PID/CRC5/CRC16 checking, token and SOF field
// extraction, CRC-stripped payload streaming. Optional macro: USB_RX_ADDR_FILTER_EN.
module usb_rx_packet #(
    parameter int MAX_PAYLOAD = 1023
) (
    input  logic           CLK_60M,
    input  logic           RST_A_USB,
    usb_rx_packet_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_PAYLOAD + 4);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PAYLOAD + 2);
    localparam logic [4:0]  CRC5_RES  = 5'b00110;
    localparam logic [15:0] CRC16_RES = 16'hB001;
    localparam logic [3:0]  PID_SOF   = 4'h5;
    localparam logic [2:0]  ERR_PID   = 3'd1;
    localparam logic [2:0]  ERR_CRC   = 3'd2;
    localparam logic [2:0]  ERR_LEN   = 3'd3;
    localparam logic [2:0]  ERR_PHY   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_PID, S_TOKEN, S_DATA, S_HSK, S_DRAIN, S_DONE, S_ERR
    } state_t;

    typedef enum logic [1:0] {C_TOK, C_DATA, C_HSK, C_BAD} cls_t;

    function automatic cls_t pid_class(input logic [7:0] b);
        cls_t c;
        if (b[7:4] != ~b[3:0]) begin
            c = C_BAD;
        end else begin
            case (b[3:0])
                4'h1, 4'h9, 4'hD, 4'h5: c = C_TOK;
                4'h3, 4'hB, 4'h7, 4'hF: c = C_DATA;
                4'h2, 4'hA, 4'hE, 4'h6: c = C_HSK;
                default:                c = C_BAD;
            endcase
        end
        return c;
    endfunction

    function automatic logic [4:0] crc5_byte(input logic [4:0] crc, input logic [7:0] b);
        logic [4:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 5'h14;
            else             c = c >> 1;
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction

    state_t           state_r, state_s;
    cls_t             cls_s;
    logic [2:0]       code_s, pend_code_r;
    logic [7:0]       pid_byte_r;
    logic [CNT_W-1:0] cnt_r, cnt_now_s;
    logic [4:0]       crc5_r, crc5_now_s;
    logic [15:0]      crc16_r, crc16_now_s;
    logic [7:0]       tok_b1_r, tok_b2_r, tok_hi_s;
    logic [10:0]      tok_field_s;
    logic [7:0]       dly0_r, dly1_r;
    logic             start_s, proc_s, addr_drop_s;

    logic [3:0]  pid_r, pid_s;
    logic [6:0]  tok_addr_r, tok_addr_s;
    logic [3:0]  tok_endp_r, tok_endp_s;
    logic [10:0] frame_r, frame_s;
    logic [7:0]  pay_data_r, pay_data_s;
    logic        pay_strb_r, pay_strb_s;
    logic [10:0] pay_len_r, pay_len_s;
    logic        done_r, done_s, err_r, err_s, busy_r, busy_s;
    logic [2:0]  err_code_r, err_code_s;

    // start_s: states in which an incoming strobe is the PID byte of a new packet
    assign start_s     = (state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_ERR);
    assign proc_s      = (state_r == S_PID) || (state_r == S_TOKEN) ||
                         (state_r == S_DATA) || (state_r == S_HSK);
    assign cnt_now_s   = cnt_r + CNT_W'(bus.RX_STRB);
    assign crc5_now_s  = bus.RX_STRB ? crc5_byte(crc5_r, bus.RX_DATA) : crc5_r;
    assign crc16_now_s = bus.RX_STRB ? crc16_byte(crc16_r, bus.RX_DATA) : crc16_r;
    assign tok_hi_s    = bus.RX_STRB ? bus.RX_DATA : tok_b2_r;
    assign tok_field_s = {tok_hi_s[2:0], tok_b1_r};

`ifdef USB_RX_ADDR_FILTER_EN
    assign addr_drop_s = (pid_byte_r[3:0] != PID_SOF) && (tok_field_s[6:0] != bus.DEV_ADDR);
`else
    assign addr_drop_s = 1'b0;
`endif

    // Effective packet class: in S_PID it comes from the latched PID byte
    always_comb begin
        case (state_r)
            S_PID:   cls_s = pid_class(pid_byte_r);
            S_TOKEN: cls_s = C_TOK;
            S_DATA:  cls_s = C_DATA;
            S_HSK:   cls_s = C_HSK;
            default: cls_s = C_BAD;
        endcase
    end

    // State register
    always_ff @(posedge CLK_60M or posedge RST_A_USB) begin
        if (RST_A_USB) state_r <= S_IDLE;
        else           state_r <= state_s;
    end

    // Next-state and error-code selection
    always_comb begin
        state_s = state_r;
        code_s  = pend_code_r;
        case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.RX_STRB) begin
                    if (bus.RX_END) begin
                        // single-byte packet: only a handshake is complete
                        case (pid_class(bus.RX_DATA))
                            C_HSK:   state_s = S_DONE;
                            C_BAD:   begin state_s = S_ERR; code_s = ERR_PID; end
                            default: begin state_s = S_ERR; code_s = ERR_LEN; end
                        endcase
                    end else begin
                        state_s = S_PID;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PID, S_TOKEN, S_DATA, S_HSK: begin
                if (bus.RX_FAIL) begin
                    state_s = S_ERR;
                    code_s  = ERR_PHY;
                end else begin
                    case (cls_s)
                        C_TOK: begin
                            if (bus.RX_END) begin
                                if (cnt_now_s != CNT_TWO) begin
                                    state_s = S_ERR; code_s = ERR_LEN;
                                end else if (crc5_now_s != CRC5_RES) begin
                                    state_s = S_ERR; code_s = ERR_CRC;
                                end else if (addr_drop_s) begin
                                    state_s = S_IDLE;
                                end else begin
                                    state_s = S_DONE;
                                end
                            end else if (bus.RX_STRB && (cnt_now_s > CNT_TWO)) begin
                                state_s = S_DRAIN; code_s = ERR_LEN;
                            end else begin
                                state_s = S_TOKEN;
                            end
                        end
                        C_DATA: begin
                            if (bus.RX_END) begin
                                if (cnt_now_s < CNT_TWO) begin
                                    state_s = S_ERR; code_s = ERR_LEN;
                                end else if (crc16_now_s != CRC16_RES) begin
                                    state_s = S_ERR; code_s = ERR_CRC;
                                end else begin
                                    state_s = S_DONE;
                                end
                            end else if (bus.RX_STRB && (cnt_now_s > CNT_MAX)) begin
                                state_s = S_DRAIN; code_s = ERR_LEN;
                            end else begin
                                state_s = S_DATA;
                            end
                        end
                        C_HSK: begin
                            if (bus.RX_STRB) begin
                                state_s = bus.RX_END ? S_ERR : S_DRAIN;
                                code_s  = ERR_LEN;
                            end else if (bus.RX_END) begin
                                state_s = S_DONE;
                            end else begin
                                state_s = S_HSK;
                            end
                        end
                        default: begin
                            state_s = bus.RX_END ? S_ERR : S_DRAIN;
                            code_s  = ERR_PID;
                        end
                    endcase
                end
            end
            S_DRAIN: begin
                if (bus.RX_FAIL) begin
                    state_s = S_ERR;
                    code_s  = ERR_PHY;
                end else if (bus.RX_END) begin
                    state_s = S_ERR;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Output next values, registered below
    always_comb begin
        pid_s      = pid_r;
        tok_addr_s = tok_addr_r;
        tok_endp_s = tok_endp_r;
        frame_s    = frame_r;
        pay_len_s  = pay_len_r;
        done_s     = (state_s == S_DONE);
        err_s      = (state_s == S_ERR);
        err_code_s = err_s ? code_s : err_code_r;
        busy_s     = (state_s == S_PID) || (state_s == S_TOKEN) || (state_s == S_DATA) ||
                     (state_s == S_HSK) || (state_s == S_DRAIN);
        if (done_s || err_s) begin
            pid_s = start_s ? bus.RX_DATA[3:0] : pid_byte_r[3:0];
        end else begin
            pid_s = pid_r;
        end
        if (done_s && proc_s && (cls_s == C_TOK)) begin
            if (pid_byte_r[3:0] == PID_SOF) begin
                frame_s = tok_field_s;
            end else begin
                tok_addr_s = tok_field_s[6:0];
                tok_endp_s = tok_field_s[10:7];
            end
        end else begin
            frame_s = frame_r;
        end
        if (done_s) begin
            pay_len_s = (proc_s && (cls_s == C_DATA)) ? 11'(cnt_now_s - CNT_TWO) : 11'd0;
        end else begin
            pay_len_s = pay_len_r;
        end
        // a payload byte leaves the delay line once two newer bytes sit behind it
        pay_strb_s = proc_s && (cls_s == C_DATA) && bus.RX_STRB && !bus.RX_FAIL &&
                     (cnt_r >= CNT_TWO);
        pay_data_s = pay_strb_s ? dly0_r : pay_data_r;
    end

    // Output registers
    always_ff @(posedge CLK_60M or posedge RST_A_USB) begin
        if (RST_A_USB) begin
            pid_r      <= 4'd0;
            tok_addr_r <= 7'd0;
            tok_endp_r <= 4'd0;
            frame_r    <= 11'd0;
            pay_data_r <= 8'd0;
            pay_strb_r <= 1'b0;
            pay_len_r  <= 11'd0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= 3'd0;
            busy_r     <= 1'b0;
        end else begin
            pid_r      <= pid_s;
            tok_addr_r <= tok_addr_s;
            tok_endp_r <= tok_endp_s;
            frame_r    <= frame_s;
            pay_data_r <= pay_data_s;
            pay_strb_r <= pay_strb_s;
            pay_len_r  <= pay_len_s;
            done_r     <= done_s;
            err_r      <= err_s;
            err_code_r <= err_code_s;
            busy_r     <= busy_s;
        end
    end

    // Packet datapath: PID latch, byte count, running CRCs, token bytes, CRC-strip delay line
    always_ff @(posedge CLK_60M or posedge RST_A_USB) begin
        if (RST_A_USB) begin
            pend_code_r <= 3'd0;
            pid_byte_r  <= 8'd0;
            cnt_r       <= '0;
            crc5_r      <= 5'h1F;
            crc16_r     <= 16'hFFFF;
            tok_b1_r    <= 8'd0;
            tok_b2_r    <= 8'd0;
            dly0_r      <= 8'd0;
            dly1_r      <= 8'd0;
        end else begin
            pend_code_r <= code_s;
            if (start_s && bus.RX_STRB) begin
                pid_byte_r <= bus.RX_DATA;
                cnt_r      <= '0;
                crc5_r     <= 5'h1F;
                crc16_r    <= 16'hFFFF;
            end else if (proc_s && bus.RX_STRB) begin
                cnt_r   <= cnt_now_s;
                crc5_r  <= crc5_now_s;
                crc16_r <= crc16_now_s;
                dly0_r  <= dly1_r;
                dly1_r  <= bus.RX_DATA;
                if (cnt_r == '0)          tok_b1_r <= bus.RX_DATA;
                else if (cnt_r == CNT_W'(1)) tok_b2_r <= bus.RX_DATA;
                else                      tok_b2_r <= tok_b2_r;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign bus.PID          = pid_r;
    assign bus.TOK_ADDR     = tok_addr_r;
    assign bus.TOK_ENDP     = tok_endp_r;
    assign bus.FRAME_NUM    = frame_r;
    assign bus.PAY_DATA     = pay_data_r;
    assign bus.PAY_STRB     = pay_strb_r;
    assign bus.PAY_LEN      = pay_len_r;
    assign bus.PKT_DONE     = done_r;
    assign bus.PKT_ERR      = err_r;
    assign bus.PKT_ERR_CODE = err_code_r;
    assign bus.BUSY         = busy_r;

endmodule

// File: tb/tb_usb_rx_packet.sv
// Directed self-checking bench for usb_rx_packet with hand-computed packets and CRCs.
module tb_usb_rx_packet;

    logic clk = 1'b0;
    logic rst;
    usb_rx_packet_if bus();

    usb_rx_packet #(.MAX_PAYLOAD(1023)) dut (
        .CLK_60M   (clk),
        .RST_A_USB (rst),
        .bus       (bus)
    );

    always #8 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] pay_q[$];
    logic [7:0] tx_q[$];
    int         done_cnt = 0;
    int         err_cnt  = 0;
    logic [1:0] pulse_r;

    // Collect payload bytes and result pulses away from the active edge
    always @(negedge clk) begin
        if (bus.PAY_STRB) pay_q.push_back(bus.PAY_DATA);
        if (bus.PKT_DONE) done_cnt++;
        if (bus.PKT_ERR)  err_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        pay_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.RX_STRB = 1'b0; bus.RX_END = 1'b0; bus.RX_FAIL = 1'b0; bus.RX_DATA = 8'h00;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.RX_STRB = 1'b1; bus.RX_DATA = b; bus.RX_END = 1'b0; bus.RX_FAIL = 1'b0;
    endtask

    task automatic send_end(input logic with_byte, input logic [7:0] b);
        @(negedge clk);
        bus.RX_STRB = with_byte; bus.RX_DATA = b; bus.RX_END = 1'b1; bus.RX_FAIL = 1'b0;
        @(negedge clk);
        bus.RX_STRB = 1'b0; bus.RX_END = 1'b0;
        pulse_r = {bus.PKT_DONE, bus.PKT_ERR};
    endtask

    task automatic send_q(input logic same_cycle_end);
        clr();
        for (int i = 0; i < tx_q.size(); i++) begin
            if (same_cycle_end && (i == tx_q.size() - 1)) send_end(1'b1, tx_q[i]);
            else                                           send_byte(tx_q[i]);
        end
        if (!same_cycle_end) send_end(1'b0, 8'h00);
        idle(3);
    endtask

    logic [7:0] exp_setup [8] = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};

    initial begin
        bus.RX_STRB = 1'b0; bus.RX_END = 1'b0; bus.RX_FAIL = 1'b0; bus.RX_DATA = 8'h00;
`ifdef USB_RX_ADDR_FILTER_EN
        bus.DEV_ADDR = 7'd0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_outs", {bus.PID, bus.TOK_ADDR, bus.TOK_ENDP, bus.FRAME_NUM, bus.PAY_LEN},
                 32'd0);
        check_eq("rst_flags", {bus.PKT_DONE, bus.PKT_ERR, bus.PKT_ERR_CODE, bus.BUSY,
                               bus.PAY_STRB, bus.PAY_DATA}, 32'd0);
        rst = 1'b0;
        idle(2);

        // IN token addr 0 endp 0
        tx_q = '{8'h69, 8'h00, 8'h10};
        send_q(1'b0);
        check_eq("in_latency", 32'(pulse_r), 32'h2);
        check_eq("in_done", done_cnt, 1);
        check_eq("in_err", err_cnt, 0);
        check_eq("in_pid", bus.PID, 4'h9);
        check_eq("in_addr_endp", {bus.TOK_ADDR, bus.TOK_ENDP}, 11'd0);
        check_eq("in_busy_after", bus.BUSY, 1'b0);

        tx_q = '{8'h69, 8'h00, 8'h11};
        send_q(1'b0);
        check_eq("in_badcrc_err", err_cnt, 1);
        check_eq("in_badcrc_code", bus.PKT_ERR_CODE, 3'd2);

        // OUT token addr 0x15 endp 0xE
        tx_q = '{8'hE1, 8'h15, 8'hEF};
        send_q(1'b1);
        check_eq("out_done", done_cnt, 1);
        check_eq("out_fields", {bus.PID, bus.TOK_ADDR, bus.TOK_ENDP}, {4'h1, 7'h15, 4'hE});

        // SOF frame 0x710
        tx_q = '{8'hA5, 8'h10, 8'h2F};
        send_q(1'b0);
        check_eq("sof_done", done_cnt, 1);
        check_eq("sof_frame", bus.FRAME_NUM, 11'h710);
        check_eq("sof_keeps_addr", bus.TOK_ADDR, 7'h15);

        // DATA0 setup payload
        tx_q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        send_q(1'b0);
        check_eq("setup_done", done_cnt, 1);
        check_eq("setup_len", bus.PAY_LEN, 11'd8);
        check_eq("setup_pid", bus.PID, 4'h3);
        check_eq("setup_nbytes", pay_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("setup_pay%0d", i),
                     (i < pay_q.size()) ? 32'(pay_q[i]) : 32'hDEAD, 32'(exp_setup[i]));
        end

        tx_q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h95};
        send_q(1'b1);
        check_eq("setup_bad_err", err_cnt, 1);
        check_eq("setup_bad_done", done_cnt, 0);
        check_eq("setup_bad_code", bus.PKT_ERR_CODE, 3'd2);

        // empty DATA1
        tx_q = '{8'h4B, 8'h00, 8'h00};
        send_q(1'b1);
        check_eq("empty_done", done_cnt, 1);
        check_eq("empty_len", bus.PAY_LEN, 11'd0);
        check_eq("empty_nbytes", pay_q.size(), 0);
        check_eq("empty_pid", bus.PID, 4'hB);

        // handshakes
        tx_q = '{8'hD2};
        send_q(1'b0);
        check_eq("ack_done", done_cnt, 1);
        check_eq("ack_pid", bus.PID, 4'h2);
        tx_q = '{8'h5A};
        send_q(1'b1);
        check_eq("nak_same_cycle", 32'(pulse_r), 32'h2);
        check_eq("nak_pid", bus.PID, 4'hA);
        tx_q = '{8'hD2, 8'h00};
        send_q(1'b0);
        check_eq("ack_extra_err", err_cnt, 1);
        check_eq("ack_extra_code", bus.PKT_ERR_CODE, 3'd3);

        // bad PID complement
        tx_q = '{8'h68, 8'h00};
        send_q(1'b0);
        check_eq("badpid_err", err_cnt, 1);
        check_eq("badpid_code", bus.PKT_ERR_CODE, 3'd1);

        // short token
        tx_q = '{8'h69, 8'h00};
        send_q(1'b0);
        check_eq("short_tok_code", {err_cnt[3:0], bus.PKT_ERR_CODE}, {4'd1, 3'd3});

        // PHY failure mid DATA
        clr();
        send_byte(8'hC3); send_byte(8'h80); send_byte(8'h06);
        @(negedge clk);
        bus.RX_STRB = 1'b0; bus.RX_FAIL = 1'b1;
        @(negedge clk);
        bus.RX_FAIL = 1'b0;
        check_eq("fail_pulse", bus.PKT_ERR, 1'b1);
        check_eq("fail_code", bus.PKT_ERR_CODE, 3'd4);
        idle(3);

        // oversize payload, then a clean SETUP
        clr();
        send_byte(8'hC3);
        for (int i = 0; i < 1028; i++) send_byte(8'h00);
        idle(1);
        check_eq("ovf_no_early_pulse", err_cnt + done_cnt, 0);
        send_end(1'b0, 8'h00);
        idle(3);
        check_eq("ovf_err", err_cnt, 1);
        check_eq("ovf_code", bus.PKT_ERR_CODE, 3'd3);
        tx_q = '{8'h2D, 8'h00, 8'h10};
        send_q(1'b0);
        check_eq("after_ovf_done", done_cnt, 1);
        check_eq("after_ovf_pid", bus.PID, 4'hD);

        // reset in the middle of a DATA packet
        clr();
        send_byte(8'hC3); send_byte(8'h80); send_byte(8'h06);
        idle(1);
        check_eq("busy_mid_data", bus.BUSY, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_outs", {bus.PID, bus.FRAME_NUM, bus.PAY_LEN, bus.PKT_ERR_CODE}, 32'd0);
        check_eq("midrst_flags", {bus.BUSY, bus.PKT_DONE, bus.PKT_ERR, bus.PAY_STRB}, 32'd0);
        rst = 1'b0;
        idle(3);
        check_eq("midrst_no_pulse", done_cnt + err_cnt, 0);
        tx_q = '{8'hD2};
        send_q(1'b0);
        check_eq("midrst_recover", done_cnt, 1);

`ifdef USB_RX_ADDR_FILTER_EN
        bus.DEV_ADDR = 7'd5;
        tx_q = '{8'h69, 8'h00, 8'h10};
        send_q(1'b0);
        check_eq("filt_no_pulse", done_cnt + err_cnt, 0);
        check_eq("filt_busy", bus.BUSY, 1'b0);
        tx_q = '{8'hA5, 8'h10, 8'h2F};
        send_q(1'b0);
        check_eq("filt_sof_done", done_cnt, 1);
        check_eq("filt_sof_frame", bus.FRAME_NUM, 11'h710);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/usb_rx_packet.md
Name: usb_rx_packet

Overview:
Packet-level receiver directly downstream of the ULPI PHY interface. It consumes the ULPI receive byte stream (data, strobe, end, fail) and parses each USB packet. For every packet it validates the PID and the CRC5 or CRC16, extracts token fields and the SOF frame number, and forwards the data payload with both CRC bytes stripped. Results go to the device/endpoint layer as single-cycle done or error pulses.

Parameters:
MAX_PAYLOAD, 1023, maximum payload bytes accepted in a DATA packet (CRC excluded); a longer payload is an error.

Ports:
CLK_60M  in  1  ULPI 60 MHz clock; all logic on its rising edge
RST_A_USB  in  1  asynchronous reset, active-high
RX_DATA  in  8  received byte from the ULPI block
RX_STRB  in  1  RX_DATA valid this cycle
RX_END  in  1  pulse: the packet ended normally
RX_FAIL  in  1  pulse: the PHY reported an RX error; abort the packet
PID  out  4  PID[3:0] of the last finished packet
TOK_ADDR  out  7  token address field
TOK_ENDP  out  4  token endpoint field
FRAME_NUM  out  11  last valid SOF frame number
PAY_DATA  out  8  payload byte
PAY_STRB  out  1  PAY_DATA valid
PAY_LEN  out  11  payload byte count, valid with PKT_DONE
PKT_DONE  out  1  pulse: valid packet finished
PKT_ERR  out  1  pulse: packet rejected
PKT_ERR_CODE  out  3  1=PID, 2=CRC, 3=length, 4=PHY fail; held until the next PKT_ERR
BUSY  out  1  high from the first byte until DONE/ERR

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset mid-packet discards the packet and emits no pulse.
- FSM states: IDLE, PID, TOKEN, DATA, HSK, DRAIN, DONE, ERR.
- IDLE: the first RX_STRB byte is the PID byte. It is valid only when RX_DATA[7:4] == ~RX_DATA[3:0]. Invalid -> DRAIN, code 1.
- PID class decides the next state:
  - token class (OUT 1, IN 9, SETUP D, SOF 5) -> TOKEN
  - data class (DATA0 3, DATA1 B, DATA2 7, MDATA F) -> DATA
  - handshake class (ACK 2, NAK A, STALL E, NYET 6) -> HSK
  - any other PID -> DRAIN, code 1.
- TOKEN:
  - Collects exactly 2 bytes: 11-bit field {byte2[2:0], byte1} plus CRC5 = byte2[7:3].
  - CRC5: LSB-first, shift-right register, init 5'h1F, reflected polynomial 5'h14, run over all 16 bits. Register must equal 5'b00110 after the 16th bit.
  - RX_END after exactly 2 bytes with good CRC -> DONE. SOF updates FRAME_NUM; other tokens update TOK_ADDR = field[6:0] and TOK_ENDP = field[10:7].
  - Fewer or more than 2 bytes -> code 3. Bad CRC -> code 2.
- DATA:
  - CRC16: LSB-first, init 16'hFFFF, reflected polynomial 16'hA001, run over payload and both CRC bytes. Register must equal 16'hB001 at RX_END.
  - A 2-byte delay line strips the CRC. Byte n is emitted on PAY_STRB one cycle after byte n+2 is strobed in, so the two CRC bytes are never emitted.
  - At RX_END: fewer than 2 bytes -> code 3; CRC mismatch -> code 2; otherwise DONE with PAY_LEN = bytes - 2.
  - A payload that would exceed MAX_PAYLOAD -> DRAIN, code 3, immediately.
  - Consumers discard already-streamed bytes on PKT_ERR.
- HSK: RX_END with no further byte -> DONE. Any extra byte -> DRAIN, code 3.
- DRAIN: ignores bytes until RX_END or RX_FAIL, then ERR.
- DONE and ERR each last one cycle, pulse PKT_DONE or PKT_ERR, update PID, then return to IDLE.
- RX_FAIL in any non-IDLE state: next state is ERR with code 4. RX_FAIL in IDLE is ignored.
- RX_STRB and RX_END in the same cycle: the byte is consumed first, then the end is evaluated including that byte.
- Back-to-back packets: a strobe arriving in the DONE/ERR cycle is captured as the next PID byte.
- Latency: PKT_DONE/PKT_ERR occur 1 cycle after RX_END.

Optional Feature:
USB_RX_ADDR_FILTER_EN
- Defined: adds input DEV_ADDR[6:0]. A token whose address differs from DEV_ADDR, SOF excepted, ends with no pulse and no field update. The FSM returns to IDLE.
- Undefined: no DEV_ADDR port; every valid token is reported.

Test Plan:
- Bytes 69 00 10 then END -> PKT_DONE, PID=9, TOK_ADDR=0, TOK_ENDP=0. Bytes 69 00 11 -> PKT_ERR, code 2.
- Bytes C3 80 06 00 01 00 00 40 00 DD 94 then END -> 8 PAY_STRB bytes 80 06 00 01 00 00 40 00, PKT_DONE, PAY_LEN=8, PID=3. Flip the last byte to 95 -> PKT_ERR, code 2.
- Bytes 4B 00 00 then END -> PKT_DONE, PAY_LEN=0, no PAY_STRB. Byte D2 then END -> PKT_DONE, PID=2. Bytes D2 00 -> PKT_ERR, code 3.
- Byte 69 whose complement check fails (e.g. 68) -> DRAIN, PKT_ERR code 1 after END. RX_FAIL mid-DATA -> PKT_ERR code 4 next cycle.
- DATA with 1026 payload bytes, MAX_PAYLOAD=1023 -> PKT_ERR code 3; next packet 2D 00 10 parses cleanly. Assert RST_A_USB mid-DATA -> all outputs 0, no pulse.
- With USB_RX_ADDR_FILTER_EN, DEV_ADDR=5: 69 00 10 -> no pulse. SOF with good CRC -> FRAME_NUM updated.
